// File: rtl/or_gate_pkg.sv
// -----------------------------------------------------------------------------
// or_gate_pkg
// Shared constants and types for the or_gate primitive.
//   OR_GATE_CNT_W   : default width of the activity statistics counters
//   cnt_t           : counter type at the default width
//   OR_GATE_CNT_MAX : saturation value of a default-width counter
// -----------------------------------------------------------------------------
package or_gate_pkg;

    localparam int OR_GATE_CNT_W = 16;

    typedef logic [OR_GATE_CNT_W-1:0] cnt_t;

    localparam cnt_t OR_GATE_CNT_MAX = '1;

endpackage : or_gate_pkg

// File: rtl/or_gate_edge_det.sv
// -----------------------------------------------------------------------------
// or_gate_edge_det
// Per-bit register pair: registers the input once (q), then again (q delayed),
// and flags rising/falling transitions of q in the same cycle q changes.
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset (clears both register stages)
//   d     : [WIDTH] value to register
//   q     : [WIDTH] d registered on clk
//   rise  : [WIDTH] q went 0->1 this cycle (1-cycle pulse)
//   fall  : [WIDTH] q went 1->0 this cycle (1-cycle pulse)
// -----------------------------------------------------------------------------
module or_gate_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] cur_d;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] prev_q;

    always_comb begin
        cur_d  = d;
        prev_d = cur_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    // Pulses are decoded from the two stages so they line up with the
    // cycle in which q itself changes; both stages reset to 0 so a 1 seen
    // on the first edge after reset produces a rise pulse.
    assign q    = cur_q;
    assign rise = cur_q & ~prev_q;
    assign fall = ~cur_q & prev_q;

endmodule : or_gate_edge_det

// File: rtl/or_gate.sv
// -----------------------------------------------------------------------------
// or_gate
// Bitwise two-input OR with a zero-latency combinational result, a registered
// copy, per-bit edge pulses and optional activity statistics.
// Optional feature macro: OR_GATE_STATS_EN (adds stat_clr, high_cnt, rise_cnt).
// Ports:
//   clk      : system clock, rising-edge active
//   rst_n    : asynchronous active-low reset (never affects out)
//   a, b     : [WIDTH] operands
//   out      : [WIDTH] a | b, purely combinational
//   out_q    : [WIDTH] out registered on clk
//   rise     : [WIDTH] out_q went 0->1 (1-cycle pulse)
//   fall     : [WIDTH] out_q went 1->0 (1-cycle pulse)
//   stat_clr : synchronous clear of both counters, wins over increment
//   high_cnt : [CNT_W] saturating count of cycles with out_q[0]=1
//   rise_cnt : [CNT_W] saturating count of rise[0] pulses
// -----------------------------------------------------------------------------
module or_gate
    import or_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = OR_GATE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef OR_GATE_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] rise_cnt
`endif
);

    // No clock or reset dependency on the primary result.
    assign out = a | b;

    or_gate_edge_det #(
        .WIDTH (WIDTH)
    ) u_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (out),
        .q     (out_q),
        .rise  (rise),
        .fall  (fall)
    );

`ifdef OR_GATE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] high_cnt_d;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] rise_cnt_d;
    logic [CNT_W-1:0] rise_cnt_q;

    always_comb begin
        high_cnt_d = high_cnt_q;
        rise_cnt_d = rise_cnt_q;
        if (stat_clr) begin
            high_cnt_d = '0;
            rise_cnt_d = '0;
        end else begin
            // Counters stick at all-ones rather than wrapping.
            if (out_q[0] && (high_cnt_q != CNT_MAX)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
            if (rise[0] && (rise_cnt_q != CNT_MAX)) begin
                rise_cnt_d = rise_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt_q <= '0;
            rise_cnt_q <= '0;
        end else begin
            high_cnt_q <= high_cnt_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    assign high_cnt = high_cnt_q;
    assign rise_cnt = rise_cnt_q;
`endif

endmodule : or_gate

// File: tb/tb_or_gate.sv
module tb_or_gate;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clk_run;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
`ifdef OR_GATE_STATS_EN
    logic             stat_clr;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] rise_cnt;
`endif

    int vectors;
    int miscompares;

    or_gate #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .out      (out),
        .out_q    (out_q),
        .rise     (rise),
        .fall     (fall)
`ifdef OR_GATE_STATS_EN
        ,
        .stat_clr (stat_clr),
        .high_cnt (high_cnt),
        .rise_cnt (rise_cnt)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for one rising edge, then settle 1 time unit.
    task automatic tick();
        fork
            begin : wait_edge
                @(posedge clk);
            end
            begin : wait_limit
                #100;
                miscompares++;
                $display("FAIL clock_timeout observed=none expected=posedge");
            end
        join_any
        disable fork;
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [WIDTH-1:0] eq,
                              input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] ef);
        check({tag, "_out_q"}, 32'(out_q), 32'(eq));
        check({tag, "_rise"},  32'(rise),  32'(er));
        check({tag, "_fall"},  32'(fall),  32'(ef));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_run     = 1'b0;
        a           = '0;
        b           = '0;
        rst_n       = 1'b1;
`ifdef OR_GATE_STATS_EN
        stat_clr    = 1'b0;
`endif
        #1;
        rst_n = 1'b0;

        // Truth table with no clock running (and reset asserted).
        a = 4'b0000; b = 4'b0000; #1; check("tt_00", 32'(out), 32'h0); #1;
        a = 4'b1111; b = 4'b0000; #1; check("tt_10", 32'(out), 32'hf); #1;
        a = 4'b0000; b = 4'b1111; #1; check("tt_01", 32'(out), 32'hf); #1;
        a = 4'b1111; b = 4'b1111; #1; check("tt_11", 32'(out), 32'hf); #1;
        a = 4'b0000; b = 4'b0000; #1; check("tt_00b", 32'(out), 32'h0); #1;
        a = 4'b1010; b = 4'b0110; #1; check("tt_mix", 32'(out), 32'he); #1;
        a = 4'b1100; b = 4'b0011; #1; check("tt_mix2", 32'(out), 32'hf); #1;

        // Reset held, a=1: out follows, registered side stays zero.
        a = 4'b0001; b = 4'b0000; #1;
        check("rst_out", 32'(out), 32'h1);
        check_regs("rst", 4'b0000, 4'b0000, 4'b0000);
`ifdef OR_GATE_STATS_EN
        check("rst_high", 32'(high_cnt), 32'h0);
        check("rst_risec", 32'(rise_cnt), 32'h0);
`endif
        clk_run = 1'b1;
        tick();
        tick();
        check_regs("rst_clk", 4'b0000, 4'b0000, 4'b0000);

        // Release between edges; first edge captures the 1 and pulses rise.
        rst_n = 1'b1;
        tick();
        check_regs("rel_e1", 4'b0001, 4'b0001, 4'b0000);
        tick();
        check_regs("rel_e2", 4'b0001, 4'b0000, 4'b0000);
`ifdef OR_GATE_STATS_EN
        check("cnt_e2_high", 32'(high_cnt), 32'h1);
        check("cnt_e2_rise", 32'(rise_cnt), 32'h1);
        for (int i = 3; i <= 8; i++) tick();
        check("cnt_e8_high", 32'(high_cnt), 32'h7);

        // Asynchronous reset between edges clears counters at once.
        rst_n = 1'b0;
        #1;
        check("arst_high", 32'(high_cnt), 32'h0);
        check("arst_risec", 32'(rise_cnt), 32'h0);
        check_regs("arst", 4'b0000, 4'b0000, 4'b0000);
        a = 4'b0100; b = 4'b0001; #1;
        check("arst_out", 32'(out), 32'h5);
        a = 4'b0001; b = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check_regs("arst_rel", 4'b0001, 4'b0001, 4'b0000);
        for (int i = 2; i <= 20; i++) tick();
        check("sat_high", 32'(high_cnt), 32'hf);
        check("sat_rise", 32'(rise_cnt), 32'h1);
        stat_clr = 1'b1;
        tick();
        check("clr_high", 32'(high_cnt), 32'h0);
        check("clr_rise", 32'(rise_cnt), 32'h0);
        stat_clr = 1'b0;
        tick();
        check("postclr_high", 32'(high_cnt), 32'h1);
`else
        // Mid-operation asynchronous reset without statistics.
        rst_n = 1'b0;
        #1;
        check_regs("arst", 4'b0000, 4'b0000, 4'b0000);
        a = 4'b0100; b = 4'b0001; #1;
        check("arst_out", 32'(out), 32'h5);
        a = 4'b0001; b = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check_regs("arst_rel", 4'b0001, 4'b0001, 4'b0000);
`endif

        // Drop to 0, then a 0->1->0 pattern held 3 cycles each.
        a = 4'b0000;
        tick();
        check_regs("fall_a", 4'b0000, 4'b0000, 4'b0001);
        tick();
        tick();
        check_regs("low_c3", 4'b0000, 4'b0000, 4'b0000);
        a = 4'b0001;
        tick(); check_regs("pul_c1", 4'b0001, 4'b0001, 4'b0000);
        tick(); check_regs("pul_c2", 4'b0001, 4'b0000, 4'b0000);
        tick(); check_regs("pul_c3", 4'b0001, 4'b0000, 4'b0000);
        a = 4'b0000;
        tick(); check_regs("pul_c4", 4'b0000, 4'b0000, 4'b0001);
        tick(); check_regs("pul_c5", 4'b0000, 4'b0000, 4'b0000);

        // Multi-bit operands.
        a = 4'b1010; b = 4'b0110; #1;
        check("w4_out", 32'(out), 32'he);
        tick(); check_regs("w4_c1", 4'b1110, 4'b1110, 4'b0000);
        a = 4'b0011; b = 4'b0000;
        tick(); check_regs("w4_c2", 4'b0011, 4'b0001, 4'b1100);
        a = 4'b0000;
        tick(); check_regs("w4_c3", 4'b0000, 4'b0000, 4'b0011);

        // Glitch narrower than a period, placed between edges.
        #2;
        b = 4'b1000; #1;
        check("gl_out", 32'(out), 32'h8);
        b = 4'b0000; #1;
        check("gl_out_back", 32'(out), 32'h0);
        tick();
        check_regs("gl_reg", 4'b0000, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_or_gate
